fp16_addsub_seq: RTL and testbench
==================================

Name: fp16_addsub_seq

Overview:
Multi-cycle sequencer for the 16-bit half-precision adder/subtractor path.
- Accepts an operand pair with an operation select over a valid/ready handshake.
- Unpacks the operands to 13-bit extended mantissas: [12] hidden, [11:2] fraction, [1] guard, [0] round.
- Aligns the smaller operand one bit per cycle, adds or subtracts, normalizes iteratively, then packs.
- Presents the result on a second valid/ready handshake. Sits between the operand source and the result consumer and replaces the single-cycle combinational align/add path.

Parameters:
MAX_SHIFT, 13, alignment shift cap; an exponent difference at or above this value zeroes the smaller mantissa in one cycle.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
op_valid  in  1  operand pair valid
op_ready  out  1  block can accept (high only in IDLE)
op_a  in  16  operand A, IEEE-754 binary16
op_b  in  16  operand B, binary16
op_sub  in  1  1 = A-B, 0 = A+B
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  16  binary16 result
res_flags  out  3  {invalid, overflow, zero}
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE, op_ready=1, res_valid=0, res_data=0, res_flags=0, busy=0, internal counters and registers cleared. An in-flight operation is discarded.
- States: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> PACK -> DONE -> IDLE.
- IDLE: on op_valid&&op_ready, capture op_a, op_b and op_sub (op_sub inverts B's sign); go to UNPACK.
- UNPACK (1 cycle):
  - Exponent 0 is flushed to zero (subnormals not supported).
  - Exponent 31 on either operand (NaN/Inf) skips to PACK:
    - Inf-Inf of opposite effective signs -> 0x7E00, invalid=1.
    - Any NaN -> 0x7E00, invalid=1.
    - Otherwise the Inf passes through.
  - Normal path: operands swapped so the larger exponent is in slot L; new_exp = larger exponent; shift_cnt = |expA-expB| saturated to MAX_SHIFT.
- ALIGN: shift the slot-S mantissa right by 1 per cycle, decrementing shift_cnt. Exit when shift_cnt==0, which takes 0 cycles of shifting for equal exponents.
  - If the difference is >= MAX_SHIFT, S is zeroed in a single cycle instead.
  - Bits shifted out OR into a sticky register.
- ADD (1 cycle): 14-bit result.
  - Equal effective signs: sum = L+S.
  - Otherwise: magnitude difference, with the sign taken from the larger magnitude. Mantissas are compared when exponents are equal.
  - Exact zero result -> +0 (0x0000), zero flag=1, go to PACK.
- NORM:
  - If sum[13]=1: shift right 1, new_exp+1 (single cycle).
  - Else while sum[12]==0: shift left 1 and new_exp-1, one per cycle.
  - If new_exp would reach 0 -> flush to signed zero, zero=1.
- PACK (1 cycle):
  - Round per the optional feature.
  - If a rounding carry sets the mantissa overflow, renormalize once.
  - If new_exp>=31 -> signed Inf (0x7C00/0xFC00), overflow=1.
  - Register res_data and res_flags.
- DONE: res_valid=1. res_data and res_flags are held stable until res_ready. On res_ready: res_valid=0, go to IDLE, op_ready=1 on the following cycle.
- Latency from accept to res_valid = 4 + align cycles + norm cycles; bounded at 4+13+12 = 29 cycles.
- Back-pressure: DONE holds indefinitely; no new operand is accepted until the result is consumed.

Optional Feature:
FP16_RNE_EN.
- Defined: round-to-nearest-even in PACK using guard, round and sticky; sticky is tracked through ALIGN and NORM.
- Undefined: truncation; the sticky register and rounding logic are not instantiated; guard and round bits are dropped.

Decomposition:
- Package fp16_pkg:
  - state enum.
  - Field widths: EXP_W=5, FRAC_W=10, EXT_MANT_W=13.
  - EXP_MAX=31, BIAS=15.
  - Constants QNAN=16'h7E00, POS_INF=16'h7C00.
  - Flag bit indices.
- One sub-module: fp16_round_pack, combinational. Takes sign, exponent, extended mantissa and sticky; returns the packed word plus the overflow flag.

Test Plan:
1. 0x3C00 + 0x3C00, op_sub=0 -> res_data=0x4000, flags=000; ALIGN 0 shift cycles, NORM 1 cycle; res_valid at accept+6.
2. 0x4200 - 0x3C00 -> 0x4000. 0x3C00 - 0x3C00 -> 0x0000 with zero=1.
3. 0x3C00 + 0x1400 -> 0x3C01; exactly 10 ALIGN cycles observed on busy/state.
4. 0x7BFF + 0x7BFF -> 0x7C00, overflow=1. 0x7C00 - 0x7C00 -> 0x7E00, invalid=1.
5. Hold res_ready=0 for 20 cycles after res_valid -> res_data stable and op_ready=0 throughout. Assert rst mid-ALIGN -> op_ready=1 and res_valid=0 immediately, with no stale result afterward.
6. FP16_RNE_EN defined: 0x3C00 + 0x1000 -> 0x3C00 (tie to even). 0x3C01 + 0x1000 -> 0x3C02. Undefined: both cases truncate (0x3C00, 0x3C01).

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared types and constants for the binary16 add/subtract sequencer.
// FP16_RNE_EN selects round-to-nearest-even instead of truncation.
package fp16_pkg;

  localparam int EXP_W      = 5;
  localparam int FRAC_W     = 10;
  localparam int EXT_MANT_W = 13;
  localparam int EXP_MAX    = 31;
  localparam int BIAS       = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  localparam int FLG_INVALID  = 2;
  localparam int FLG_OVERFLOW = 1;
  localparam int FLG_ZERO     = 0;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_UNPACK = 3'd1;
  localparam state_t S_ALIGN  = 3'd2;
  localparam state_t S_ADD    = 3'd3;
  localparam state_t S_NORM   = 3'd4;
  localparam state_t S_PACK   = 3'd5;
  localparam state_t S_DONE   = 3'd6;

  function automatic logic [2:0] mk_flags(
    input logic inv,
    input logic ovf,
    input logic zero
  );
    mk_flags               = '0;
    mk_flags[FLG_INVALID]  = inv;
    mk_flags[FLG_OVERFLOW] = ovf;
    mk_flags[FLG_ZERO]     = zero;
  endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Rounds a normalized extended mantissa and packs it into binary16.
// FP16_RNE_EN selects round-to-nearest-even, otherwise truncation.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic                  sign,
  input  logic [EXP_W:0]        exp_in,
  input  logic [EXT_MANT_W-1:0] mant,
  input  logic                  sticky,
  output logic [15:0]           data,
  output logic                  overflow
);

  logic [EXP_W:0]  exp_r;
  logic [FRAC_W-1:0] frac;

`ifdef FP16_RNE_EN
  logic              rnd_up;
  logic [FRAC_W+1:0] rm;

  always_comb begin
    rnd_up = mant[1] & (mant[0] | sticky | mant[2]);
    rm     = {1'b0, mant[12:2]}
           + {{(FRAC_W+1){1'b0}}, rnd_up};
    // carry out of the hidden bit renormalizes once
    exp_r  = exp_in + {{EXP_W{1'b0}}, rm[FRAC_W+1]};
    frac   = rm[FRAC_W+1] ? rm[FRAC_W:1]
                          : rm[FRAC_W-1:0];
  end
`else
  logic unused_bits;

  assign unused_bits = ^{sticky, mant[12], mant[1:0]};

  always_comb begin
    exp_r = exp_in;
    frac  = mant[11:2];
  end
`endif

  always_comb begin
    overflow = (exp_r >= (EXP_W+1)'(EXP_MAX));
    data     = overflow ? {sign, POS_INF[14:0]}
                        : {sign, exp_r[EXP_W-1:0], frac};
  end

endmodule

// File: rtl/fp16_addsub_seq.sv
// Multi-cycle binary16 adder/subtractor with valid/ready handshakes.
// FP16_RNE_EN enables sticky tracking and round-to-nearest-even.
module fp16_addsub_seq
  import fp16_pkg::*;
#(
  parameter int MAX_SHIFT = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        op_sub,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [2:0]  res_flags,
  output logic        busy
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);
  localparam logic [CNT_W-1:0] SHIFT_CAP = CNT_W'(MAX_SHIFT);

  state_t                state;
  logic [15:0]           a_q;
  logic [15:0]           b_q;
  logic                  sign_l;
  logic                  sign_s;
  logic [EXT_MANT_W-1:0] mant_l;
  logic [EXT_MANT_W-1:0] mant_s;
  logic [EXP_W:0]        new_exp;
  logic [CNT_W-1:0]      shift_cnt;
  logic [EXT_MANT_W:0]   sum;
  logic                  res_sign;
  logic                  special;
  logic [15:0]           spec_data;
  logic [2:0]            spec_flags;

  logic [EXP_W-1:0]      ea;
  logic [EXP_W-1:0]      eb;
  logic [EXT_MANT_W-1:0] ma;
  logic [EXT_MANT_W-1:0] mb;
  logic                  a_ge;
  logic [EXP_W-1:0]      diff;
  logic                  nan_a;
  logic                  nan_b;
  logic [EXT_MANT_W:0]   sum_nx;
  logic                  sign_nx;
  logic                  rp_sticky;
  logic [15:0]           rp_data;
  logic                  rp_ovf;

  assign op_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // exponent 0 is flushed: subnormals carry no hidden bit
  always_comb begin
    ea    = a_q[14:10];
    eb    = b_q[14:10];
    ma    = (ea == '0) ? '0 : {1'b1, a_q[9:0], 2'b00};
    mb    = (eb == '0) ? '0 : {1'b1, b_q[9:0], 2'b00};
    a_ge  = (ea >= eb);
    diff  = a_ge ? (ea - eb) : (eb - ea);
    nan_a = (&ea) && (a_q[9:0] != '0);
    nan_b = (&eb) && (b_q[9:0] != '0);
  end

  always_comb begin
    sum_nx  = '0;
    sign_nx = sign_l;
    if (sign_l == sign_s)
      sum_nx = {1'b0, mant_l} + {1'b0, mant_s};
    else if (mant_l >= mant_s)
      sum_nx = {1'b0, mant_l} - {1'b0, mant_s};
    else begin
      sum_nx  = {1'b0, mant_s} - {1'b0, mant_l};
      sign_nx = sign_s;
    end
  end

`ifdef FP16_RNE_EN
  logic sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sticky <= 1'b0;
    else if (state == S_UNPACK)
      sticky <= 1'b0;
    else if (state == S_ALIGN) begin
      if (shift_cnt >= SHIFT_CAP)
        sticky <= sticky | (|mant_s);
      else if (shift_cnt != '0)
        sticky <= sticky | mant_s[0];
    end else if (state == S_NORM && sum[EXT_MANT_W])
      sticky <= sticky | sum[0];
  end

  assign rp_sticky = sticky;
`else
  assign rp_sticky = 1'b0;
`endif

  fp16_round_pack u_round_pack (
    .sign     (res_sign),
    .exp_in   (new_exp),
    .mant     (sum[EXT_MANT_W-1:0]),
    .sticky   (rp_sticky),
    .data     (rp_data),
    .overflow (rp_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_l     <= 1'b0;
      sign_s     <= 1'b0;
      mant_l     <= '0;
      mant_s     <= '0;
      new_exp    <= '0;
      shift_cnt  <= '0;
      sum        <= '0;
      res_sign   <= 1'b0;
      special    <= 1'b0;
      spec_data  <= '0;
      spec_flags <= '0;
      res_data   <= '0;
      res_flags  <= '0;
      res_valid  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (op_valid && op_ready) begin
            a_q   <= op_a;
            b_q   <= {op_b[15] ^ op_sub, op_b[14:0]};
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          special    <= 1'b0;
          spec_data  <= '0;
          spec_flags <= '0;
          if ((&ea) || (&eb)) begin
            special <= 1'b1;
            state   <= S_PACK;
            if (nan_a || nan_b ||
                ((&ea) && (&eb) && (a_q[15] != b_q[15]))) begin
              spec_data  <= QNAN;
              spec_flags <= mk_flags(1'b1, 1'b0, 1'b0);
            end else if (&ea)
              spec_data <= {a_q[15], POS_INF[14:0]};
            else
              spec_data <= {b_q[15], POS_INF[14:0]};
          end else begin
            if (a_ge) begin
              sign_l  <= a_q[15];
              mant_l  <= ma;
              sign_s  <= b_q[15];
              mant_s  <= mb;
              new_exp <= {1'b0, ea};
            end else begin
              sign_l  <= b_q[15];
              mant_l  <= mb;
              sign_s  <= a_q[15];
              mant_s  <= ma;
              new_exp <= {1'b0, eb};
            end
            shift_cnt <= (diff >= EXP_W'(MAX_SHIFT))
                       ? SHIFT_CAP : CNT_W'(diff);
            state     <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (shift_cnt >= SHIFT_CAP) begin
            mant_s    <= '0;
            shift_cnt <= '0;
            state     <= S_ADD;
          end else if (shift_cnt == '0)
            state <= S_ADD;
          else begin
            mant_s    <= mant_s >> 1;
            shift_cnt <= shift_cnt - 1'b1;
            if (shift_cnt == CNT_W'(1))
              state <= S_ADD;
          end
        end
        S_ADD: begin
          if (sum_nx == '0) begin
            special    <= 1'b1;
            spec_data  <= '0;
            spec_flags <= mk_flags(1'b0, 1'b0, 1'b1);
            state      <= S_PACK;
          end else begin
            sum      <= sum_nx;
            res_sign <= sign_nx;
            state    <= S_NORM;
          end
        end
        S_NORM: begin
          if (sum[EXT_MANT_W]) begin
            sum     <= sum >> 1;
            new_exp <= new_exp + 1'b1;
            state   <= S_PACK;
          end else if (!sum[EXT_MANT_W-1]) begin
            if (new_exp <= (EXP_W+1)'(1)) begin
              special    <= 1'b1;
              spec_data  <= {res_sign, 15'd0};
              spec_flags <= mk_flags(1'b0, 1'b0, 1'b1);
              state      <= S_PACK;
            end else begin
              sum     <= sum << 1;
              new_exp <= new_exp - 1'b1;
            end
          end else
            state <= S_PACK;
        end
        S_PACK: begin
          res_data  <= special ? spec_data : rp_data;
          res_flags <= special ? spec_flags
                               : mk_flags(1'b0, rp_ovf, 1'b0);
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_addsub_seq.sv
// Directed bench for fp16_addsub_seq: vectors, latency, back-pressure, reset.
// Expected rounding results follow FP16_RNE_EN.
module tb_fp16_addsub_seq;
  import fp16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        op_sub = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [2:0]  res_flags;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp16_addsub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // start an op; returns the cycle index of res_valid (accept cycle = 0)
  task automatic start_op(input logic [15:0] a,
                          input logic [15:0] b,
                          input logic sub,
                          output int lat,
                          output int nal);
    int t;
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; op_valid = 1'b1;
    t = 0;
    while (!op_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", {31'd0, op_ready}, 32'd1);
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    nal = 0;
    while (!res_valid && lat < 60) begin
      if (dut.state == S_ALIGN) nal++;
      @(negedge clk);
      lat++;
    end
    check("result_timeout", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

`ifdef FP16_RNE_EN
  localparam logic [15:0] E_TIE = 16'h3C00;
  localparam logic [15:0] E_UP  = 16'h3C02;
`else
  localparam logic [15:0] E_TIE = 16'h3C00;
  localparam logic [15:0] E_UP  = 16'h3C01;
`endif

  logic [15:0] va [15];
  logic [15:0] vb [15];
  logic        vs [15];
  logic [15:0] vd [15];
  logic [2:0]  vf [15];

  initial begin
    int lat;
    int nal;
    int cnt;
    va = '{16'h3C00, 16'h4200, 16'h3C00, 16'h3C00, 16'h7BFF,
           16'h7C00, 16'h3C00, 16'h3C01, 16'h3C00, 16'h3C00,
           16'h7E01, 16'h7C00, 16'h0400, 16'h3C00, 16'hFC00};
    vb = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h1400, 16'h7BFF,
           16'h7C00, 16'h1000, 16'h1000, 16'h4000, 16'h3E00,
           16'h3C00, 16'h3C00, 16'h0500, 16'h0800, 16'h7C00};
    vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vd = '{16'h4000, 16'h4000, 16'h0000, 16'h3C01, 16'h7C00,
           16'h7E00, E_TIE,    E_UP,     16'hBC00, 16'hB800,
           16'h7E00, 16'h7C00, 16'h8000, 16'h3C00, 16'hFC00};
    vf = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010,
           3'b100, 3'b000, 3'b000, 3'b000, 3'b000,
           3'b100, 3'b000, 3'b001, 3'b000, 3'b000};

    #2;
    check("rst_op_ready", {31'd0, op_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", {16'd0, res_data}, 32'd0);
    check("rst_res_flags", {29'd0, res_flags}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      start_op(va[i], vb[i], vs[i], lat, nal);
      check($sformatf("data%0d", i), {16'd0, res_data}, {16'd0, vd[i]});
      check($sformatf("flags%0d", i), {29'd0, res_flags}, {29'd0, vf[i]});
      if (i == 0) check("lat_equal_exp", lat, 6);
      if (i == 3) begin
        check("lat_shift10", lat, 15);
        check("align_cycles10", nal, 10);
      end
      consume();
      check($sformatf("ready_after%0d", i), {31'd0, op_ready}, 32'd1);
    end

    // back-pressure: result held, no new operand accepted
    start_op(16'h3C00, 16'h3C00, 1'b0, lat, nal);
    op_valid = 1'b1;
    op_a = 16'h4400;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_data !== 16'h4000 || op_ready !== 1'b0 ||
          res_valid !== 1'b1) cnt++;
    end
    op_valid = 1'b0;
    check("backpressure_hold", cnt, 0);
    consume();

    // asynchronous reset in the middle of alignment
    start_op(16'h3C00, 16'h3C00, 1'b0, lat, nal);
    consume();
    @(negedge clk);
    op_a = 16'h3C00; op_b = 16'h1400; op_sub = 1'b0; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    cnt = 0;
    while (dut.state != S_ALIGN && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    @(negedge clk);
    check("busy_in_align", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_op_ready", {31'd0, op_ready}, 32'd1);
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_res_data", {16'd0, res_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) cnt++;
    end
    check("no_stale_result", cnt, 0);

    // operation after reset still works
    start_op(16'h4200, 16'h3C00, 1'b1, lat, nal);
    check("post_rst_data", {16'd0, res_data}, 32'h4000);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
